grey_axis_out: RTL
==================

GREY_AXIS_OUT -- requirements
Module: grey_axis_out

Interface
REQ-001 Parameter DATA_WIDTH, default 8: pixel width, matching the upstream greyscale FIFO word.
REQ-002 Parameter IMG_WIDTH, default 640: pixels per line (minimum 2).
REQ-003 Parameter IMG_HEIGHT, default 480: lines per frame (minimum 1).
REQ-004 i_clk  in  1: single clock; all state SHALL be updated on its rising edge.
REQ-005 i_rst  in  1: asynchronous, active-high reset.
REQ-006 i_enable  in  1: run request; sampled only at frame boundaries.
REQ-007 i_fifo_data  in  DATA_WIDTH: FIFO head word, valid whenever i_fifo_empty=0 (zero-latency read).
REQ-008 i_fifo_empty  in  1: FIFO empty flag.
REQ-009 o_fifo_rd  out  1: FIFO read strobe; advances the FIFO read pointer.
REQ-010 m_axis_tdata  out  DATA_WIDTH: AXI4-Stream pixel data.
REQ-011 m_axis_tvalid  out  1: AXI4-Stream valid.
REQ-012 m_axis_tready  in  1: AXI4-Stream ready.
REQ-013 m_axis_tuser  out  1: start of frame, 1 on pixel (0,0) only.
REQ-014 m_axis_tlast  out  1: end of line, 1 on column IMG_WIDTH-1.
REQ-015 o_busy  out  1: 1 when state is not IDLE.

Function
REQ-016 FSM states IDLE, RUN and STOPPING SHALL be used; the reset state SHALL be IDLE.
REQ-017 IDLE->RUN when i_enable=1; the column and row counters SHALL both be 0 on entering RUN.
REQ-018 RUN->STOPPING when i_enable=0 mid-frame; STOPPING SHALL keep streaming until the pixel at (IMG_WIDTH-1, IMG_HEIGHT-1) is loaded, then go to IDLE.
REQ-019 At the end of a frame in RUN, the block SHALL stay in RUN if i_enable=1 and SHALL go to IDLE otherwise; no frame SHALL be truncated.
REQ-020 o_fifo_rd SHALL be combinational: (state!=IDLE) && !i_fifo_empty && (!m_axis_tvalid || m_axis_tready).
REQ-021 On o_fifo_rd=1, the output register SHALL load tdata=i_fifo_data, tvalid=1, tlast=(col==IMG_WIDTH-1) and tuser=(col==0 && row==0).
REQ-022 When o_fifo_rd=0 and m_axis_tready=1, tvalid SHALL go to 0.
REQ-023 While tvalid=1 and tready=0, tdata, tuser and tlast SHALL hold stable and no FIFO read SHALL occur.
REQ-024 Latency from the FIFO going non-empty to tvalid SHALL be 1 cycle, with sustained throughput of 1 pixel per cycle.
REQ-025 col SHALL increment on each load and wrap from IMG_WIDTH-1 to 0; row SHALL then increment and wrap from IMG_HEIGHT-1 to 0 (frame end).
REQ-026 Counter widths SHALL be $clog2 of the respective parameter.
REQ-027 An already-valid output beat SHALL complete its handshake even when the FSM has returned to IDLE.

Reset
REQ-028 On i_rst=1: state=IDLE, col=0, row=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, o_busy=0, o_fifo_rd=0.
REQ-029 Reset mid-frame SHALL discard the partial frame and the pending beat; the next frame SHALL restart at (0,0) with tuser=1.

Configuration
REQ-030 Macro GREY_AXIS_FRAME_CNT_EN: when defined, the block SHALL add output o_frame_cnt [15:0], reset to 0, incremented on the tready handshake of each beat with tlast=1 at row IMG_HEIGHT-1, and wrapping at 65535->0.
REQ-031 When GREY_AXIS_FRAME_CNT_EN is not defined, the o_frame_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 IMG_WIDTH=4, IMG_HEIGHT=2, enable=1, FIFO preloaded with 8 words 0x10..0x17, tready=1 -> 8 consecutive beats; tuser on 0x10 only; tlast on 0x13 and 0x17.
REQ-033 tready held low for 5 cycles after the first beat -> tdata=0x10 held stable, o_fifo_rd=0 throughout, no pixels lost after tready returns to 1.
REQ-034 FIFO empty for 3 cycles mid-line -> tvalid=0 in the gap; column count continues correctly, with tlast on the 4th pixel of the line.
REQ-035 i_enable dropped at pixel 2 of frame 0 -> remaining 6 pixels still streamed, state returns to IDLE, o_busy=0, no further FIFO reads.
REQ-036 i_rst pulsed after 3 beats, then enable -> the next beat carries tuser=1 and tlast lands at the 4th beat after reset.
REQ-037 With GREY_AXIS_FRAME_CNT_EN, 3 full frames streamed -> o_frame_cnt=3.

Source files
------------

// File: rtl/grey_axis_out.sv
// Greyscale FIFO to AXI4-Stream video adapter: frame-aligned start/stop, SOF on tuser, EOL on tlast.
// Define GREY_AXIS_FRAME_CNT_EN to add the o_frame_cnt completed-frame counter output.
module grey_axis_out #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
`ifdef GREY_AXIS_FRAME_CNT_EN
    output logic [15:0]           o_frame_cnt,
`endif
    output logic                  o_busy
);

    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
    localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tuser_q, tuser_d;
    logic                    tlast_q, tlast_d;
    logic                    busy_q, busy_d;

    logic                    load_s;
    logic                    col_last_s;
    logic                    row_last_s;
    logic                    frame_end_s;
    logic                    frame_open_s;

    // Read/load strobe and frame-position decodes
    always_comb begin
        load_s       = (state_q != ST_IDLE) && !i_fifo_empty && (!tvalid_q || m_axis_tready);
        col_last_s   = (col_q == COL_LAST);
        row_last_s   = (row_q == ROW_LAST);
        frame_end_s  = load_s && col_last_s && row_last_s;
        // A frame is open once its first pixel is being or has been loaded
        frame_open_s = load_s || (col_q != COL_ZERO) || (row_q != ROW_ZERO);
    end

    // Next-state, pixel counters and output beat register
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;

        if (load_s) begin
            if (col_last_s) begin
                col_d = COL_ZERO;
                if (row_last_s) begin
                    row_d = ROW_ZERO;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
                row_d = row_q;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end

        case (state_q)
            ST_IDLE: begin
                col_d = COL_ZERO;
                row_d = ROW_ZERO;
                if (i_enable) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (frame_end_s) begin
                    state_d = i_enable ? ST_RUN : ST_IDLE;
                end else if (!i_enable) begin
                    state_d = frame_open_s ? ST_STOPPING : ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STOPPING: begin
                if (frame_end_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOPPING;
                end
            end
            default: begin
                state_d = ST_IDLE;
                col_d   = COL_ZERO;
                row_d   = ROW_ZERO;
            end
        endcase

        // A pending beat drains on tready regardless of FSM state
        if (load_s) begin
            tdata_d  = i_fifo_data;
            tvalid_d = 1'b1;
            tlast_d  = col_last_s;
            tuser_d  = (col_q == COL_ZERO) && (row_q == ROW_ZERO);
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and output register update
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            col_q    <= COL_ZERO;
            row_q    <= ROW_ZERO;
            tdata_q  <= {DATA_WIDTH{1'b0}};
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
        end
    end

`ifdef GREY_AXIS_FRAME_CNT_EN
    logic        eof_q, eof_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Marks the beat that closes a frame and counts its handshake
    always_comb begin
        if (load_s) begin
            eof_d = col_last_s && row_last_s;
        end else begin
            eof_d = eof_q;
        end
        if (tvalid_q && m_axis_tready && tlast_q && eof_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            eof_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            eof_q       <= eof_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
`endif

    assign o_fifo_rd     = load_s;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign o_busy        = busy_q;

endmodule
